// File: rtl/money_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | money_pkg : shared width, mode encoding and read-FSM state type      |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package money_pkg;

  localparam int MONEY_W = 4;

  localparam logic MODE_MACHINE  = 1'b0;
  localparam logic MODE_CUSTOMER = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    RESP    = 2'd2
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/money_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | money_if : write port, read handshake and live money values          |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
interface money_if #(
  parameter int MONEY_W = money_pkg::MONEY_W
);

  logic               wr_en;
  logic               wr_mode;
  logic [MONEY_W-1:0] wr_value;
  logic               rd_req;
  logic               rd_mode;
  logic               rd_ack;
  logic               rd_busy;
  logic               rd_valid;
  logic [MONEY_W-1:0] rd_data;
  logic               rd_mode_out;
  logic               rd_stale;
  logic [MONEY_W-1:0] machine_money;
  logic [MONEY_W-1:0] customer_money;
  logic [MONEY_W:0]   total_money;

  modport master (
    output wr_en, wr_mode, wr_value, rd_req, rd_mode, rd_ack,
    input  rd_busy, rd_valid, rd_data, rd_mode_out, rd_stale,
    input  machine_money, customer_money, total_money
  );

  modport slave (
    input  wr_en, wr_mode, wr_value, rd_req, rd_mode, rd_ack,
    output rd_busy, rd_valid, rd_data, rd_mode_out, rd_stale,
    output machine_money, customer_money, total_money
  );

endinterface
`default_nettype wire

// File: rtl/money_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | money_reg : single money register with write enable and reset value  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module money_reg #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             we,
  input  wire logic [WIDTH-1:0] d,
  output logic      [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_value <= INIT;
    end else if (we) begin
      r_value <= d;
    end
  end

  assign q = r_value;

endmodule
`default_nettype wire

// File: rtl/money_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | money_reader : machine/customer money storage with snapshot read     |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module money_reader
  import money_pkg::*;
#(
  parameter int                        MONEY_W       = money_pkg::MONEY_W,
  parameter logic [MONEY_W-1:0]        MACHINE_INIT  = '0,
  parameter logic [MONEY_W-1:0]        CUSTOMER_INIT = '0
) (
  input wire logic clock,
  input wire logic reset,
  money_if.slave   bus
);

  logic [MONEY_W-1:0] w_machine;
  logic [MONEY_W-1:0] w_customer;
  logic               w_wr_machine;
  logic               w_wr_customer;
  logic [MONEY_W-1:0] w_sel_value;
  logic               w_sel_write;

  rd_state_t          r_state;
  logic               r_mode_q;
  logic               r_rd_busy;
  logic               r_rd_valid;
  logic [MONEY_W-1:0] r_rd_data;
  logic               r_rd_mode_out;
  logic               r_rd_stale;

  assign w_wr_machine  = bus.wr_en && (bus.wr_mode == MODE_MACHINE);
  assign w_wr_customer = bus.wr_en && (bus.wr_mode == MODE_CUSTOMER);

  money_reg #(
    .WIDTH (MONEY_W),
    .INIT  (MACHINE_INIT)
  ) u_machine (
    .clock (clock),
    .reset (reset),
    .we    (w_wr_machine),
    .d     (bus.wr_value),
    .q     (w_machine)
  );

  money_reg #(
    .WIDTH (MONEY_W),
    .INIT  (CUSTOMER_INIT)
  ) u_customer (
    .clock (clock),
    .reset (reset),
    .we    (w_wr_customer),
    .d     (bus.wr_value),
    .q     (w_customer)
  );

  // Snapshot source and "source written this edge" both follow the latched mode.
  assign w_sel_value = (r_mode_q == MODE_CUSTOMER) ? w_customer : w_machine;
  assign w_sel_write = bus.wr_en && (bus.wr_mode == r_mode_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_mode_q      <= MODE_MACHINE;
      r_rd_busy     <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rd_data     <= '0;
      r_rd_mode_out <= 1'b0;
      r_rd_stale    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.rd_req) begin
            r_mode_q  <= bus.rd_mode;
            r_rd_busy <= 1'b1;
            r_state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          r_rd_data     <= w_sel_value;
          r_rd_stale    <= w_sel_write;
          r_rd_mode_out <= r_mode_q;
          r_state       <= RESP;
        end
        RESP: begin
          // rd_valid rises on the first RESP edge; only then is rd_ack honoured.
          if (r_rd_valid && bus.rd_ack) begin
            r_rd_valid <= 1'b0;
            r_rd_busy  <= 1'b0;
            r_rd_stale <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_rd_valid <= 1'b1;
            if (w_sel_write) begin
              r_rd_stale <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_rd_busy  <= 1'b0;
          r_rd_valid <= 1'b0;
          r_rd_stale <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_busy        = r_rd_busy;
  assign bus.rd_valid       = r_rd_valid;
  assign bus.rd_data        = r_rd_data;
  assign bus.rd_mode_out    = r_rd_mode_out;
  assign bus.rd_stale       = r_rd_stale;
  assign bus.machine_money  = w_machine;
  assign bus.customer_money = w_customer;
  assign bus.total_money    = {1'b0, w_machine} + {1'b0, w_customer};

endmodule
`default_nettype wire
